ret_addr_stack: RTL and testbench

RET_ADDR_STACK -- requirements
Module: ret_addr_stack

---
 rtl/ret_addr_stack_if.sv | 28 ++
 rtl/ret_addr_stack.sv | 94 +++++++++
 tb/tb_ret_addr_stack.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/ret_addr_stack_if.sv
// Return-address stack bus: CALL/RET/flush controls in, top/occupancy/error status out.
interface ret_addr_stack_if #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 10
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic          RAS_PUSH;
    logic          RAS_POP;
    logic          RAS_CLR;
    logic [AW-1:0] RAS_DIN;
    logic [AW-1:0] RAS_TOP;
    logic [CW-1:0] RAS_CNT;
    logic          RAS_EMPTY;
    logic          RAS_FULL;
    logic          RAS_OVF;
    logic          RAS_UNF;

    modport master (
        output RAS_PUSH, RAS_POP, RAS_CLR, RAS_DIN,
        input  RAS_TOP, RAS_CNT, RAS_EMPTY, RAS_FULL, RAS_OVF, RAS_UNF
    );

    modport slave (
        input  RAS_PUSH, RAS_POP, RAS_CLR, RAS_DIN,
        output RAS_TOP, RAS_CNT, RAS_EMPTY, RAS_FULL, RAS_OVF, RAS_UNF
    );
endinterface

// File: rtl/ret_addr_stack.sv
// Saturating return-address stack with zero-latency top read and sticky overflow/underflow flags.
module ret_addr_stack #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 10
) (
    input  logic              RAS_CLK,
    input  logic              RAS_RST_N,
    ret_addr_stack_if.slave   ras
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0] r_mem [DEPTH];
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic          r_unf;

    logic [CW-1:0] w_cnt_d;
    logic [CW-1:0] w_cnt_m1;
    logic [PW-1:0] w_top_idx;
    logic [PW-1:0] w_wr_idx;
    logic          w_we;
    logic          w_ovf_d;
    logic          w_unf_d;
    logic          w_empty;
    logic          w_full;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == FULL_CNT);
    assign w_cnt_m1  = r_cnt - CW'(1);
    assign w_top_idx = w_cnt_m1[PW-1:0];

    always_comb begin
        w_cnt_d  = r_cnt;
        w_ovf_d  = r_ovf;
        w_unf_d  = r_unf;
        w_we     = 1'b0;
        w_wr_idx = r_cnt[PW-1:0];
        if (ras.RAS_CLR) begin
            w_cnt_d = '0;
            w_ovf_d = 1'b0;
            w_unf_d = 1'b0;
        end else if (ras.RAS_PUSH && ras.RAS_POP) begin
            w_we = 1'b1;
            if (w_empty) begin
                // Nothing to pop: behaves as a plain push into slot 0, flagged as underflow.
                w_cnt_d = CW'(1);
                w_unf_d = 1'b1;
            end else begin
                w_wr_idx = w_top_idx;
            end
        end else if (ras.RAS_PUSH) begin
            if (w_full) begin
                w_ovf_d = 1'b1;
            end else begin
                w_we    = 1'b1;
                w_cnt_d = r_cnt + CW'(1);
            end
        end else if (ras.RAS_POP) begin
            if (w_empty) begin
                w_unf_d = 1'b1;
            end else begin
                w_cnt_d = w_cnt_m1;
            end
        end
    end

    always_ff @(posedge RAS_CLK or negedge RAS_RST_N) begin
        if (!RAS_RST_N) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_cnt <= w_cnt_d;
            r_ovf <= w_ovf_d;
            r_unf <= w_unf_d;
        end
    end

    // Entry storage is intentionally unreset; the count alone defines validity.
    always_ff @(posedge RAS_CLK) begin
        if (w_we) begin
            r_mem[w_wr_idx] <= ras.RAS_DIN;
        end
    end

    assign ras.RAS_TOP   = w_empty ? '0 : r_mem[w_top_idx];
    assign ras.RAS_CNT   = r_cnt;
    assign ras.RAS_EMPTY = w_empty;
    assign ras.RAS_FULL  = w_full;
    assign ras.RAS_OVF   = r_ovf;
    assign ras.RAS_UNF   = r_unf;
endmodule

// File: tb/tb_ret_addr_stack.sv
// Directed self-checking bench for ret_addr_stack (DEPTH=8, AW=10).
module tb_ret_addr_stack;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    ret_addr_stack_if #(.DEPTH(8), .AW(10)) ras_if ();

    ret_addr_stack #(.DEPTH(8), .AW(10)) dut (
        .RAS_CLK   (clk),
        .RAS_RST_N (rst_n),
        .ras       (ras_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one set of controls for exactly one rising edge; returns 1 time unit after it.
    task automatic cycle(input logic push, input logic pop, input logic clr,
                         input logic [9:0] din);
        ras_if.RAS_PUSH = push;
        ras_if.RAS_POP  = pop;
        ras_if.RAS_CLR  = clr;
        ras_if.RAS_DIN  = din;
        @(posedge clk);
        #1;
        ras_if.RAS_PUSH = 1'b0;
        ras_if.RAS_POP  = 1'b0;
        ras_if.RAS_CLR  = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if (ras_if.RAS_CNT !== 4'd0) begin
            n_errors++; $display("FAIL reset_cnt: got %0d want 0", ras_if.RAS_CNT);
        end
        n_checks++;
        if (ras_if.RAS_TOP !== 10'h000) begin
            n_errors++; $display("FAIL reset_top: got %h want 000", ras_if.RAS_TOP);
        end
        n_checks++;
        if ({ras_if.RAS_EMPTY, ras_if.RAS_FULL, ras_if.RAS_OVF, ras_if.RAS_UNF} !== 4'b1000) begin
            n_errors++;
            $display("FAIL reset_flags: got e/f/o/u=%b%b%b%b want 1000", ras_if.RAS_EMPTY,
                     ras_if.RAS_FULL, ras_if.RAS_OVF, ras_if.RAS_UNF);
        end
    endtask

    task automatic test_push_pop();
        logic [9:0] exp_top [3];
        exp_top[0] = 10'h3FF; exp_top[1] = 10'h012; exp_top[2] = 10'h005;
        cycle(1'b1, 1'b0, 1'b0, 10'h005);
        cycle(1'b1, 1'b0, 1'b0, 10'h012);
        cycle(1'b1, 1'b0, 1'b0, 10'h3FF);
        n_checks++;
        if (ras_if.RAS_CNT !== 4'd3 || ras_if.RAS_TOP !== 10'h3FF) begin
            n_errors++;
            $display("FAIL push3: got cnt=%0d top=%h want cnt=3 top=3ff", ras_if.RAS_CNT,
                     ras_if.RAS_TOP);
        end
        for (int i = 0; i < 3; i++) begin
            ras_if.RAS_POP = 1'b1;
            #1;
            n_checks++;
            if (ras_if.RAS_TOP !== exp_top[i]) begin
                n_errors++;
                $display("FAIL pop_same_cycle_top%0d: got %h want %h", i, ras_if.RAS_TOP,
                         exp_top[i]);
            end
            cycle(1'b0, 1'b1, 1'b0, 10'h000);
        end
        n_checks++;
        if (ras_if.RAS_TOP !== 10'h000 || ras_if.RAS_EMPTY !== 1'b1 || ras_if.RAS_CNT !== 4'd0)
        begin
            n_errors++;
            $display("FAIL pop_to_empty: got top=%h empty=%b cnt=%0d want 000 1 0",
                     ras_if.RAS_TOP, ras_if.RAS_EMPTY, ras_if.RAS_CNT);
        end
    endtask

    task automatic test_full_ovf();
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 10'h100 + 10'(i));
        n_checks++;
        if (ras_if.RAS_FULL !== 1'b1 || ras_if.RAS_TOP !== 10'h107 || ras_if.RAS_CNT !== 4'd8)
        begin
            n_errors++;
            $display("FAIL fill: got full=%b top=%h cnt=%0d want 1 107 8", ras_if.RAS_FULL,
                     ras_if.RAS_TOP, ras_if.RAS_CNT);
        end
        n_checks++;
        if (ras_if.RAS_OVF !== 1'b0) begin
            n_errors++; $display("FAIL fill_no_ovf: got %b want 0", ras_if.RAS_OVF);
        end
        cycle(1'b1, 1'b0, 1'b0, 10'h200);
        n_checks++;
        if (ras_if.RAS_OVF !== 1'b1 || ras_if.RAS_TOP !== 10'h107 || ras_if.RAS_CNT !== 4'd8)
        begin
            n_errors++;
            $display("FAIL overflow: got ovf=%b top=%h cnt=%0d want 1 107 8", ras_if.RAS_OVF,
                     ras_if.RAS_TOP, ras_if.RAS_CNT);
        end
        cycle(1'b0, 1'b1, 1'b0, 10'h000);
        n_checks++;
        if (ras_if.RAS_TOP !== 10'h106 || ras_if.RAS_CNT !== 4'd7 || ras_if.RAS_OVF !== 1'b1)
        begin
            n_errors++;
            $display("FAIL pop_after_ovf: got top=%h cnt=%0d ovf=%b want 106 7 1",
                     ras_if.RAS_TOP, ras_if.RAS_CNT, ras_if.RAS_OVF);
        end
    endtask

    task automatic test_unf_clr();
        cycle(1'b0, 1'b0, 1'b1, 10'h000);
        n_checks++;
        if (ras_if.RAS_OVF !== 1'b0 || ras_if.RAS_CNT !== 4'd0) begin
            n_errors++;
            $display("FAIL clr_after_ovf: got ovf=%b cnt=%0d want 0 0", ras_if.RAS_OVF,
                     ras_if.RAS_CNT);
        end
        cycle(1'b0, 1'b1, 1'b0, 10'h000);
        n_checks++;
        if (ras_if.RAS_UNF !== 1'b1 || ras_if.RAS_CNT !== 4'd0) begin
            n_errors++;
            $display("FAIL underflow: got unf=%b cnt=%0d want 1 0", ras_if.RAS_UNF,
                     ras_if.RAS_CNT);
        end
        cycle(1'b1, 1'b0, 1'b0, 10'h0C3);
        n_checks++;
        if (ras_if.RAS_UNF !== 1'b1 || ras_if.RAS_TOP !== 10'h0C3) begin
            n_errors++;
            $display("FAIL unf_sticky: got unf=%b top=%h want 1 0c3", ras_if.RAS_UNF,
                     ras_if.RAS_TOP);
        end
        // Clear wins over a simultaneous push.
        cycle(1'b1, 1'b0, 1'b1, 10'h111);
        n_checks++;
        if (ras_if.RAS_UNF !== 1'b0 || ras_if.RAS_OVF !== 1'b0 || ras_if.RAS_CNT !== 4'd0) begin
            n_errors++;
            $display("FAIL clr_priority: got unf=%b ovf=%b cnt=%0d want 0 0 0", ras_if.RAS_UNF,
                     ras_if.RAS_OVF, ras_if.RAS_CNT);
        end
    endtask

    task automatic test_push_pop_same();
        cycle(1'b1, 1'b0, 1'b0, 10'h040);
        cycle(1'b1, 1'b1, 1'b0, 10'h055);
        n_checks++;
        if (ras_if.RAS_CNT !== 4'd1 || ras_if.RAS_TOP !== 10'h055 || ras_if.RAS_UNF !== 1'b0) begin
            n_errors++;
            $display("FAIL replace_top: got cnt=%0d top=%h unf=%b want 1 055 0", ras_if.RAS_CNT,
                     ras_if.RAS_TOP, ras_if.RAS_UNF);
        end
        cycle(1'b0, 1'b1, 1'b0, 10'h000);
        cycle(1'b1, 1'b1, 1'b0, 10'h077);
        n_checks++;
        if (ras_if.RAS_CNT !== 4'd1 || ras_if.RAS_TOP !== 10'h077 || ras_if.RAS_UNF !== 1'b1) begin
            n_errors++;
            $display("FAIL replace_empty: got cnt=%0d top=%h unf=%b want 1 077 1",
                     ras_if.RAS_CNT, ras_if.RAS_TOP, ras_if.RAS_UNF);
        end
        cycle(1'b0, 1'b0, 1'b1, 10'h000);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b0, 10'h2A0 + 10'(i));
        cycle(1'b1, 1'b1, 1'b0, 10'h333);
        n_checks++;
        if (ras_if.RAS_CNT !== 4'd8 || ras_if.RAS_TOP !== 10'h333 || ras_if.RAS_OVF !== 1'b0) begin
            n_errors++;
            $display("FAIL replace_full: got cnt=%0d top=%h ovf=%b want 8 333 0", ras_if.RAS_CNT,
                     ras_if.RAS_TOP, ras_if.RAS_OVF);
        end
        cycle(1'b0, 1'b1, 1'b0, 10'h000);
        n_checks++;
        if (ras_if.RAS_TOP !== 10'h2A6) begin
            n_errors++; $display("FAIL below_replaced: got %h want 2a6", ras_if.RAS_TOP);
        end
    endtask

    task automatic test_async_reset();
        cycle(1'b0, 1'b0, 1'b1, 10'h000);
        cycle(1'b1, 1'b0, 1'b0, 10'h011);
        cycle(1'b1, 1'b0, 1'b0, 10'h022);
        cycle(1'b1, 1'b0, 1'b0, 10'h033);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (ras_if.RAS_CNT !== 4'd0 || ras_if.RAS_TOP !== 10'h000 || ras_if.RAS_EMPTY !== 1'b1)
        begin
            n_errors++;
            $display("FAIL async_reset: got cnt=%0d top=%h empty=%b want 0 000 1",
                     ras_if.RAS_CNT, ras_if.RAS_TOP, ras_if.RAS_EMPTY);
        end
        #1;
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 10'h0AA);
        n_checks++;
        if (ras_if.RAS_CNT !== 4'd1 || ras_if.RAS_TOP !== 10'h0AA) begin
            n_errors++;
            $display("FAIL push_after_reset: got cnt=%0d top=%h want 1 0aa", ras_if.RAS_CNT,
                     ras_if.RAS_TOP);
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        ras_if.RAS_PUSH = 1'b0;
        ras_if.RAS_POP  = 1'b0;
        ras_if.RAS_CLR  = 1'b0;
        ras_if.RAS_DIN  = '0;
        #3;
        test_reset();
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_push_pop();
        test_full_ovf();
        test_unf_clr();
        test_push_pop_same();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
